hs_merge_arb: RTL and testbench
===============================

Name: hs_merge_arb

Overview:
Single-clock N-channel handshake merger. Each source channel owns a one-word holding slot with a req/idle handshake. Full slots are arbitrated, round-robin or fixed-priority, onto one registered output port with valid/busy back-pressure. The block sits between multiple producer engines and one shared consumer, and is the multi-channel, parametrised successor of the single-channel handshake data path.

Parameters:
WIDTH, 32, data word width in bits
NCH, 4, number of source channels (2..16)
MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (channel 0 highest)

Ports:
clk  input  1  single clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  NCH  per-channel request; word offered this cycle
in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
in_idle  output  NCH  per-channel slot empty; the word is captured when in_valid[k] && in_idle[k]
out_busy  input  1  consumer stall
out_valid  output  1  output word present
out_data  output  WIDTH  output word
out_ch  output  CHW  source channel of out_data; CHW = max(1, $clog2(NCH))
err_ovf  output  NCH  sticky per channel: in_valid[k] was high while slot k was full

Behaviour:
- Reset (async, rst=1):
  - all slots empty, so in_idle = all 1s
  - out_valid = 0, out_data = 0, out_ch = 0, err_ovf = 0
  - round-robin pointer = 0
- Slot k:
  - full flag plus WIDTH-bit data register.
  - in_idle[k] = ~full[k], driven directly from the flop with no combinational path from inputs.
  - Capture: in_valid[k] && ~full[k] at edge T → full[k] = 1 and data latched at T+1.
  - in_valid[k] while full[k] → word ignored, slot data unchanged, err_ovf[k] set; cleared only by rst.
- Output load enable: ld = ~out_valid | ~out_busy, i.e. the register is empty or its word is consumed this cycle.
- Grant:
  - When ld and any full slot, the arbiter picks channel g combinationally.
  - At the edge: out_data = slot g data, out_ch = g, out_valid = 1, full[g] cleared.
- No full slot and ld → out_valid = 0, out_data = 0, out_ch = 0 (bus zeroed when idle).
- Stall: out_valid && out_busy → out_valid, out_data and out_ch held stable; no grant; slots keep filling.
- Transfer occurs on a cycle with out_valid && ~out_busy. A new grant loads in the same edge, so back-to-back output runs at 1 word/cycle.
- Latency: in_valid accepted at edge T, out_valid at T+2 earliest (empty output, no contention).
- Per-channel throughput: 1 word per 2 cycles. A slot freed at edge E reports in_idle=1 from E onward and may capture at E+1.
- Round-robin (MODE=0):
  - The search starts at the pointer, ascending with wrap (NCH-1 → 0).
  - After a grant to g, pointer = (g+1) mod NCH; pointer unchanged without a grant.
- Fixed (MODE=1): the lowest-index full slot wins; the pointer is unused.
- Simultaneous capture on multiple channels is independent and all succeed.
- A slot granted at edge E cannot also capture at E, because in_idle was 0.
- rst mid-operation: all held words are discarded immediately, outputs return to reset values, and no partial word appears.

Decomposition:
- Shared package hs_pkg:
  - MODE_RR = 0, MODE_FIXED = 1
  - function clog2_min1(n) for CHW
- Sub-module hs_arb_core (parameters NCH, MODE):
  - Inputs: req[NCH], en, clk, rst.
  - Outputs: gnt_vld, gnt_idx[CHW].
  - Owns the round-robin pointer and updates it on en && gnt_vld.
- Top level: slots, output register, error flags.

Test Plan:
- Single word: NCH=4, WIDTH=32; ch2 in_valid with data 0xDEADBEEF at cycle 10, out_busy=0 → in_idle[2]=0 at 11; out_valid=1, out_data=0xDEADBEEF, out_ch=2 at 12; out_valid=0 and out_data=0 at 13.
- Round-robin fairness: MODE=0; all 4 channels hold words continuously (refill whenever idle), out_busy=0 → out_ch sequence 0,1,2,3,0,1,… with one word/cycle and no channel skipped.
- Fixed priority: MODE=1; ch0 and ch3 refilled continuously → ch0 wins every time ch0 is full. ch3 is granted only on cycles when ch0 is empty, i.e. alternating 0,3,0,3 given ch0's 2-cycle refill.
- Back-pressure: out_valid=1 with data 0x11 (ch1) and out_busy=1 for 5 cycles while ch0 and ch1 refill → out_data stays 0x11, out_ch stays 1 throughout. Release at cycle 6 → next word on the following edge, with no loss or duplicate.
- Overflow: ch1 full, in_valid[1]=1 with 0x55 → err_ovf[1]=1 next cycle; the held word is still delivered unchanged; err_ovf stays set until rst.
- Reset mid-flight: 3 slots full, out_valid=1, out_busy=1; pulse rst asynchronously between edges → out_valid, out_data, out_ch and err_ovf go to 0 immediately and in_idle becomes all 1s. After release, the first grant with all channels requesting is ch0 (pointer reset).

Source files
------------

// File: rtl/hs_pkg.sv
// ---------------------------------------------------------------------------
// hs_pkg
// Shared definitions for the handshake merge/arbitration block.
//   MODE_RR / MODE_FIXED : arbitration mode selectors
//   clog2_min1()         : channel-index width, never narrower than one bit
// ---------------------------------------------------------------------------
package hs_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // Index width for n channels; a 1-channel or 2-channel index still needs 1 bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hs_merge_arb_if.sv
// ---------------------------------------------------------------------------
// hs_merge_arb_if
// Bundles the per-channel input handshake and the shared output port.
//   in_valid  [NCH]        per-channel request
//   in_data   [NCH*WIDTH]  channel k at bits [k*WIDTH +: WIDTH]
//   in_idle   [NCH]        per-channel slot empty
//   out_busy               consumer stall
//   out_valid              output word present
//   out_data  [WIDTH]      output word
//   out_ch    [CHW]        source channel of out_data
//   err_ovf   [NCH]        sticky overflow flags
// Modports: slave = merge block, master = producers/consumer side.
// ---------------------------------------------------------------------------
interface hs_merge_arb_if
  import hs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4
);
  localparam int CHW = clog2_min1(NCH);

  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_idle;
  logic                 out_busy;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [CHW-1:0]       out_ch;
  logic [NCH-1:0]       err_ovf;

  modport slave (
    input  in_valid, in_data, out_busy,
    output in_idle, out_valid, out_data, out_ch, err_ovf
  );

  modport master (
    output in_valid, in_data, out_busy,
    input  in_idle, out_valid, out_data, out_ch, err_ovf
  );

endinterface

// File: rtl/hs_arb_core.sv
// ---------------------------------------------------------------------------
// hs_arb_core
// Combinational grant selection over NCH requests with an owned round-robin
// pointer.
//   clk, rst  : clock, asynchronous active-high reset
//   req [NCH] : request vector (full slots)
//   en        : grant is taken this cycle (pointer advances on en && gnt_vld)
//   gnt_vld   : at least one request present
//   gnt_idx   : selected channel
// MODE_RR searches upward from the pointer with wrap; MODE_FIXED picks the
// lowest-index request and ignores the pointer.
// ---------------------------------------------------------------------------
module hs_arb_core
  import hs_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int MODE = MODE_RR
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NCH-1:0]               req,
  input  logic                         en,
  output logic                         gnt_vld,
  output logic [clog2_min1(NCH)-1:0]   gnt_idx
);
  localparam int CHW = clog2_min1(NCH);

  logic [CHW-1:0] r_ptr;
  int             w_j;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    w_j     = 0;
    for (int i = 0; i < NCH; i++) begin
      w_j = (MODE == MODE_RR) ? int'(r_ptr) + i : i;
      if (w_j >= NCH) w_j = w_j - NCH;
      if (!gnt_vld && req[w_j]) begin
        gnt_vld = 1'b1;
        gnt_idx = CHW'(w_j);
      end
    end
  end

  // Pointer moves just past the winner so it gets lowest precedence next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (en && gnt_vld) begin
      r_ptr <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/hs_merge_arb.sv
// ---------------------------------------------------------------------------
// hs_merge_arb
// N-channel handshake merger: one holding slot per source channel, full slots
// arbitrated (round-robin or fixed priority) onto one registered output with
// valid/busy back-pressure.
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : hs_merge_arb_if.slave (in_valid/in_data/in_idle per channel,
//          out_busy/out_valid/out_data/out_ch, err_ovf)
// Capture to output takes two edges; the output sustains one word per cycle.
// ---------------------------------------------------------------------------
module hs_merge_arb
  import hs_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int MODE  = MODE_RR
)(
  input  logic              clk,
  input  logic              rst,
  hs_merge_arb_if.slave     bus
);
  localparam int CHW = clog2_min1(NCH);

  logic [NCH-1:0]   r_full_p0;
  logic [WIDTH-1:0] r_slot_data_p0 [NCH];
  logic [NCH-1:0]   r_err;

  logic             r_out_vld_p1;
  logic [WIDTH-1:0] r_out_data_p1;
  logic [CHW-1:0]   r_out_ch_p1;

  logic             w_ld;
  logic             w_gnt_vld;
  logic [CHW-1:0]   w_gnt_idx;
  logic [NCH-1:0]   w_cap;
  logic [NCH-1:0]   w_clr;

  // Output register can accept a word when empty or when its word leaves now.
  assign w_ld  = ~r_out_vld_p1 | ~bus.out_busy;
  assign w_cap = bus.in_valid & ~r_full_p0;

  always_comb begin
    w_clr = '0;
    if (w_ld && w_gnt_vld) w_clr[w_gnt_idx] = 1'b1;
  end

  hs_arb_core #(
    .NCH  (NCH),
    .MODE (MODE)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (r_full_p0),
    .en      (w_ld),
    .gnt_vld (w_gnt_vld),
    .gnt_idx (w_gnt_idx)
  );

  // ---- stage p0: per-channel holding slots ----
  // Capture needs an empty slot and a grant needs a full one, so the set and
  // clear terms never hit the same bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full_p0 <= '0;
      r_err     <= '0;
    end else begin
      r_full_p0 <= (r_full_p0 | w_cap) & ~w_clr;
      r_err     <= r_err | (bus.in_valid & r_full_p0);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (w_cap[k]) r_slot_data_p0[k] <= bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  // ---- stage p1: registered output port ----
  // With nothing granted the bus is driven to zero rather than holding stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vld_p1  <= 1'b0;
      r_out_data_p1 <= '0;
      r_out_ch_p1   <= '0;
    end else if (w_ld) begin
      if (w_gnt_vld) begin
        r_out_vld_p1  <= 1'b1;
        r_out_data_p1 <= r_slot_data_p0[w_gnt_idx];
        r_out_ch_p1   <= w_gnt_idx;
      end else begin
        r_out_vld_p1  <= 1'b0;
        r_out_data_p1 <= '0;
        r_out_ch_p1   <= '0;
      end
    end
  end

  assign bus.in_idle   = ~r_full_p0;
  assign bus.out_valid = r_out_vld_p1;
  assign bus.out_data  = r_out_data_p1;
  assign bus.out_ch    = r_out_ch_p1;
  assign bus.err_ovf   = r_err;

endmodule

// File: tb/tb_hs_merge_arb.sv
// ---------------------------------------------------------------------------
// tb_hs_merge_arb
// Directed bench for hs_merge_arb: one round-robin and one fixed-priority
// instance (NCH=4, WIDTH=32) sharing clock and reset. Inputs are driven and
// outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_hs_merge_arb;
  import hs_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hs_merge_arb_if #(.WIDTH(32), .NCH(4)) rr_if ();
  hs_merge_arb_if #(.WIDTH(32), .NCH(4)) fx_if ();

  hs_merge_arb #(.WIDTH(32), .NCH(4), .MODE(MODE_RR)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (rr_if)
  );

  hs_merge_arb #(.WIDTH(32), .NCH(4), .MODE(MODE_FIXED)) u_fx (
    .clk (clk),
    .rst (rst),
    .bus (fx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    rr_if.in_valid = '0;
    rr_if.in_data  = '0;
    rr_if.out_busy = 1'b0;
    fx_if.in_valid = '0;
    fx_if.in_data  = '0;
    fx_if.out_busy = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rr_if.in_idle !== 4'hF) begin failures++; $display("FAIL rst_rr_idle: got %h want %h", rr_if.in_idle, 4'hF); end
    checks++; if (rr_if.out_valid !== 1'b0) begin failures++; $display("FAIL rst_rr_valid: got %b want 0", rr_if.out_valid); end
    checks++; if (rr_if.out_data !== 32'h0) begin failures++; $display("FAIL rst_rr_data: got %h want 0", rr_if.out_data); end
    checks++; if (rr_if.out_ch !== 2'd0) begin failures++; $display("FAIL rst_rr_ch: got %0d want 0", rr_if.out_ch); end
    checks++; if (rr_if.err_ovf !== 4'h0) begin failures++; $display("FAIL rst_rr_err: got %h want 0", rr_if.err_ovf); end
    checks++; if (fx_if.in_idle !== 4'hF) begin failures++; $display("FAIL rst_fx_idle: got %h want %h", fx_if.in_idle, 4'hF); end
    checks++; if (fx_if.out_valid !== 1'b0) begin failures++; $display("FAIL rst_fx_valid: got %b want 0", fx_if.out_valid); end
  endtask

  task automatic test_single_word();
    do_reset();
    rr_if.in_valid = 4'b0100;
    rr_if.in_data[95:64] = 32'hDEADBEEF;
    @(negedge clk);
    rr_if.in_valid = '0;
    checks++; if (rr_if.in_idle !== 4'b1011) begin failures++; $display("FAIL single_idle: got %b want 1011", rr_if.in_idle); end
    checks++; if (rr_if.out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid: got %b want 0", rr_if.out_valid); end
    @(negedge clk);
    checks++; if (rr_if.out_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b want 1", rr_if.out_valid); end
    checks++; if (rr_if.out_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data: got %h want deadbeef", rr_if.out_data); end
    checks++; if (rr_if.out_ch !== 2'd2) begin failures++; $display("FAIL single_ch: got %0d want 2", rr_if.out_ch); end
    checks++; if (rr_if.in_idle !== 4'hF) begin failures++; $display("FAIL single_freed: got %b want 1111", rr_if.in_idle); end
    @(negedge clk);
    checks++; if (rr_if.out_valid !== 1'b0) begin failures++; $display("FAIL single_after_valid: got %b want 0", rr_if.out_valid); end
    checks++; if (rr_if.out_data !== 32'h0) begin failures++; $display("FAIL single_after_data: got %h want 0", rr_if.out_data); end
  endtask

  // All four channels refilled whenever idle; each channel's words carry the
  // channel number in the top byte and a per-channel sequence number below.
  task automatic test_round_robin();
    int sent [4];
    int rcv  [4];
    int seen;
    bit started;
    do_reset();
    for (int k = 0; k < 4; k++) begin sent[k] = 0; rcv[k] = 0; end
    seen = 0;
    started = 1'b0;
    for (int cyc = 0; cyc < 40 && seen < 12; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (rr_if.out_valid === 1'b1) begin
        checks++; if (rr_if.out_ch !== 2'(seen % 4)) begin failures++; $display("FAIL rr_order[%0d]: got ch %0d want %0d", seen, rr_if.out_ch, seen % 4); end
        checks++; if (rr_if.out_data !== {8'(rr_if.out_ch), 24'(rcv[rr_if.out_ch])}) begin failures++; $display("FAIL rr_data[%0d]: got %h want %h", seen, rr_if.out_data, {8'(rr_if.out_ch), 24'(rcv[rr_if.out_ch])}); end
        rcv[rr_if.out_ch]++;
        seen++;
        started = 1'b1;
      end else if (started) begin
        checks++; failures++;
        $display("FAIL rr_gap: out_valid 0 after %0d words, want continuous", seen);
      end
      for (int k = 0; k < 4; k++) begin
        rr_if.in_valid[k] = rr_if.in_idle[k];
        rr_if.in_data[k*32 +: 32] = {8'(k), 24'(sent[k])};
        if (rr_if.in_idle[k]) sent[k]++;
      end
    end
    rr_if.in_valid = '0;
    if (seen < 12) begin
      checks++; failures++;
      $display("FAIL rr_timeout: got %0d words want 12", seen);
    end
  endtask

  task automatic test_fixed_priority();
    int seen;
    do_reset();
    seen = 0;
    for (int cyc = 0; cyc < 30 && seen < 8; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (fx_if.out_valid === 1'b1) begin
        checks++; if (fx_if.out_ch !== ((seen % 2 == 0) ? 2'd0 : 2'd3)) begin failures++; $display("FAIL fx_order[%0d]: got ch %0d want %0d", seen, fx_if.out_ch, (seen % 2 == 0) ? 0 : 3); end
        seen++;
      end
      fx_if.in_valid[0] = fx_if.in_idle[0];
      fx_if.in_valid[3] = fx_if.in_idle[3];
      fx_if.in_data[31:0]   = 32'hA0A0_0000 + cyc;
      fx_if.in_data[127:96] = 32'hB3B3_0000 + cyc;
    end
    fx_if.in_valid = '0;
    if (seen < 8) begin
      checks++; failures++;
      $display("FAIL fx_timeout: got %0d words want 8", seen);
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    rr_if.out_busy = 1'b1;
    rr_if.in_valid = 4'b0010;
    rr_if.in_data[63:32] = 32'h11;
    @(negedge clk);
    rr_if.in_valid = '0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++; if (rr_if.out_valid !== 1'b1 || rr_if.out_data !== 32'h11 || rr_if.out_ch !== 2'd1) begin failures++; $display("FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d want v=1 d=11 ch=1", i, rr_if.out_valid, rr_if.out_data, rr_if.out_ch); end
      if (i == 0) begin
        rr_if.in_valid = 4'b0011;
        rr_if.in_data[31:0]  = 32'h100;
        rr_if.in_data[63:32] = 32'h101;
      end else begin
        rr_if.in_valid = '0;
      end
      if (i < 4) @(negedge clk);
    end
    rr_if.out_busy = 1'b0;
    @(negedge clk);
    checks++; if (rr_if.out_valid !== 1'b1 || rr_if.out_data !== 32'h100 || rr_if.out_ch !== 2'd0) begin failures++; $display("FAIL bp_rel0: got v=%b d=%h ch=%0d want v=1 d=100 ch=0", rr_if.out_valid, rr_if.out_data, rr_if.out_ch); end
    @(negedge clk);
    checks++; if (rr_if.out_valid !== 1'b1 || rr_if.out_data !== 32'h101 || rr_if.out_ch !== 2'd1) begin failures++; $display("FAIL bp_rel1: got v=%b d=%h ch=%0d want v=1 d=101 ch=1", rr_if.out_valid, rr_if.out_data, rr_if.out_ch); end
    @(negedge clk);
    checks++; if (rr_if.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: got v=%b want 0", rr_if.out_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    rr_if.in_valid = 4'b0010;
    rr_if.in_data[63:32] = 32'h22;
    @(negedge clk);
    rr_if.in_data[63:32] = 32'h55;
    @(negedge clk);
    rr_if.in_valid = '0;
    checks++; if (rr_if.err_ovf !== 4'b0010) begin failures++; $display("FAIL ovf_flag: got %b want 0010", rr_if.err_ovf); end
    checks++; if (rr_if.out_valid !== 1'b1 || rr_if.out_data !== 32'h22 || rr_if.out_ch !== 2'd1) begin failures++; $display("FAIL ovf_word: got v=%b d=%h ch=%0d want v=1 d=22 ch=1", rr_if.out_valid, rr_if.out_data, rr_if.out_ch); end
    @(negedge clk);
    checks++; if (rr_if.out_valid !== 1'b0) begin failures++; $display("FAIL ovf_no_extra: got v=%b d=%h want v=0", rr_if.out_valid, rr_if.out_data); end
    repeat (3) @(negedge clk);
    checks++; if (rr_if.err_ovf !== 4'b0010) begin failures++; $display("FAIL ovf_sticky: got %b want 0010", rr_if.err_ovf); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    rr_if.out_busy = 1'b1;
    rr_if.in_valid = 4'b0111;
    rr_if.in_data[31:0]  = 32'h30;
    rr_if.in_data[63:32] = 32'h31;
    rr_if.in_data[95:64] = 32'h32;
    @(negedge clk);
    rr_if.in_valid = '0;
    @(negedge clk);
    rr_if.in_valid = 4'b0011;
    rr_if.in_data[31:0]  = 32'h40;
    rr_if.in_data[63:32] = 32'h41;
    @(negedge clk);
    rr_if.in_valid = '0;
    checks++; if (rr_if.in_idle !== 4'b1000 || rr_if.err_ovf !== 4'b0010 || rr_if.out_valid !== 1'b1) begin failures++; $display("FAIL mid_setup: got idle=%b err=%b v=%b want idle=1000 err=0010 v=1", rr_if.in_idle, rr_if.err_ovf, rr_if.out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rr_if.out_valid !== 1'b0 || rr_if.out_data !== 32'h0 || rr_if.out_ch !== 2'd0) begin failures++; $display("FAIL mid_out: got v=%b d=%h ch=%0d want all 0", rr_if.out_valid, rr_if.out_data, rr_if.out_ch); end
    checks++; if (rr_if.err_ovf !== 4'h0 || rr_if.in_idle !== 4'hF) begin failures++; $display("FAIL mid_slots: got err=%b idle=%b want err=0000 idle=1111", rr_if.err_ovf, rr_if.in_idle); end
    #1 rst = 1'b0;
    @(negedge clk);
    rr_if.out_busy = 1'b0;
    rr_if.in_valid = 4'hF;
    rr_if.in_data = {32'h53, 32'h52, 32'h51, 32'h50};
    @(negedge clk);
    rr_if.in_valid = '0;
    @(negedge clk);
    checks++; if (rr_if.out_valid !== 1'b1 || rr_if.out_ch !== 2'd0 || rr_if.out_data !== 32'h50) begin failures++; $display("FAIL mid_ptr: got v=%b ch=%0d d=%h want v=1 ch=0 d=50", rr_if.out_valid, rr_if.out_ch, rr_if.out_data); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_single_word();
    test_round_robin();
    test_fixed_priority();
    test_back_pressure();
    test_overflow();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
